// File: rtl/led_mux_pwm.sv
// LED matrix row scanner with per-pixel PWM brightness, inter-row blanking and
// a double-buffered frame store loaded through a valid/ready handshake.
module led_mux_pwm #(
    parameter int unsigned NUM_ROWS              = 4,
    parameter int unsigned NUM_ROWS_WIDTH        = 2,
    parameter int unsigned NUM_COLS              = 8,
    parameter int unsigned PWM_BITS              = 2,
    parameter int unsigned PRESCALE              = 2,
    parameter int unsigned PRESCALE_WIDTH        = 2,
    parameter int unsigned BLANK_TICKS           = 1,
    parameter bit          ROW_OUTPUT_ACTIVE_LOW = 1'b1,
    parameter bit          COL_OUTPUT_ACTIVE_LOW = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    i_rst_n,
    input  logic                                    i_enable,
    input  logic [NUM_ROWS*NUM_COLS*PWM_BITS-1:0]   i_pixels,
    input  logic                                    i_frame_valid,
    output logic                                    o_frame_ready,
    output logic                                    o_frame_start,
    output logic [NUM_ROWS-1:0]                     o_rows,
    output logic [NUM_COLS-1:0]                     o_cols
);

    localparam int unsigned FRAME_BITS = NUM_ROWS * NUM_COLS * PWM_BITS;
    localparam int unsigned PWM_TICKS  = (1 << PWM_BITS) - 1;
    localparam int unsigned BLANK_LAST = (BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0;
    localparam int unsigned TCNT_MAX   = (BLANK_TICKS > PWM_TICKS) ? BLANK_TICKS : PWM_TICKS;
    localparam int unsigned TCNT_W     = (TCNT_MAX > 1) ? $clog2(TCNT_MAX + 1) : 1;

    localparam logic [NUM_ROWS-1:0] ROWS_OFF = {NUM_ROWS{ROW_OUTPUT_ACTIVE_LOW}};
    localparam logic [NUM_COLS-1:0] COLS_OFF = {NUM_COLS{COL_OUTPUT_ACTIVE_LOW}};

    typedef enum logic {
        S_BLANK = 1'b0,
        S_PWM   = 1'b1
    } phase_t;

    // With no blanking configured every row slot opens directly in PWM
    localparam phase_t S_START = (BLANK_TICKS > 0) ? S_BLANK : S_PWM;

    phase_t                     phase, phase_d;
    logic [NUM_ROWS_WIDTH-1:0]  row, row_d;
    logic [TCNT_W-1:0]          tcnt, tcnt_d;
    logic [PRESCALE_WIDTH-1:0]  psc, psc_d;
    logic [FRAME_BITS-1:0]      disp, shadow;
    logic                       pending, pending_d;
    logic                       tick, boundary, swap, xfer;
    logic [NUM_ROWS-1:0]        row_act;
    logic [NUM_COLS-1:0]        col_act;
    logic [PWM_BITS-1:0]        pix;

    // State, output and frame-buffer registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase         <= S_START;
            row           <= '0;
            tcnt          <= '0;
            psc           <= '0;
            pending       <= 1'b0;
            disp          <= '0;
            shadow        <= '0;
            o_rows        <= ROWS_OFF;
            o_cols        <= COLS_OFF;
            o_frame_ready <= 1'b1;
            o_frame_start <= 1'b0;
        end else begin
            phase         <= phase_d;
            row           <= row_d;
            tcnt          <= tcnt_d;
            psc           <= psc_d;
            pending       <= pending_d;
            o_rows        <= row_act ^ ROWS_OFF;
            o_cols        <= col_act ^ COLS_OFF;
            o_frame_ready <= !pending_d;
            o_frame_start <= swap;
            if (xfer) begin
                shadow <= i_pixels;
            end
            if (swap) begin
                disp <= shadow;
            end
        end
    end

    // Scan sequencing, drive pattern and buffer handshake
    always_comb begin
        phase_d  = phase;
        row_d    = row;
        tcnt_d   = tcnt;
        psc_d    = psc;
        boundary = 1'b0;
        row_act  = '0;
        col_act  = '0;
        pix      = '0;
        tick     = (psc == PRESCALE_WIDTH'(PRESCALE - 1));

        if (!i_enable) begin
            phase_d = S_START;
            row_d   = '0;
            tcnt_d  = '0;
            psc_d   = '0;
        end else begin
            psc_d = tick ? '0 : psc + PRESCALE_WIDTH'(1);

            if (phase == S_PWM) begin
                row_act[row] = 1'b1;
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
                    pix = disp[(32'(row) * NUM_COLS + c) * PWM_BITS +: PWM_BITS];
                    if (32'(pix) > 32'(tcnt)) begin
                        col_act[c] = 1'b1;
                    end
                end
            end

            if (tick) begin
                if (phase == S_BLANK) begin
                    if (tcnt == TCNT_W'(BLANK_LAST)) begin
                        phase_d = S_PWM;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt + TCNT_W'(1);
                    end
                end else if (tcnt == TCNT_W'(PWM_TICKS - 1)) begin
                    phase_d = S_START;
                    tcnt_d  = '0;
                    if (row == NUM_ROWS_WIDTH'(NUM_ROWS - 1)) begin
                        row_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        row_d = row + NUM_ROWS_WIDTH'(1);
                    end
                end else begin
                    tcnt_d = tcnt + TCNT_W'(1);
                end
            end
        end

        // Pending frames swap at the frame boundary, or at once while disabled
        xfer      = i_frame_valid && o_frame_ready;
        swap      = pending && (boundary || !i_enable);
        pending_d = pending;
        if (xfer) begin
            pending_d = 1'b1;
        end else if (swap) begin
            pending_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_led_mux_pwm.sv
// Randomised scoreboard bench for led_mux_pwm: a position-based frame model
// predicts every output cycle, plus directed brightness/handshake/reset checks.
module tb_led_mux_pwm;

    localparam int NR       = 4;
    localparam int NC       = 8;
    localparam int PB       = 2;
    localparam int PRESCALE = 2;
    localparam int BLANK    = 1;
    localparam int PWMT     = (1 << PB) - 1;
    localparam int SLOT     = PRESCALE * (BLANK + PWMT);
    localparam int FRAME    = SLOT * NR;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [NR*NC*PB-1:0] pixels;
    logic              valid;
    logic              ready;
    logic              start;
    logic [NR-1:0]     rows;
    logic [NC-1:0]     cols;

    typedef struct packed {
        logic [NR-1:0] rows;
        logic [NC-1:0] cols;
        logic          ready;
        logic          start;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    led_mux_pwm dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_enable     (en),
        .i_pixels     (pixels),
        .i_frame_valid(valid),
        .o_frame_ready(ready),
        .o_frame_start(start),
        .o_rows       (rows),
        .o_cols       (cols)
    );

    initial begin
        clk = 1'b0;
        #10;
        forever begin
            #5 clk = 1'b1;
            #5 clk = 1'b0;
        end
    end

    // Reference model: scan position in clocks since the scan (re)started
    initial begin
        int                  p;
        bit                  pending;
        logic [NR*NC*PB-1:0] shadow, disp;
        exp_t                e;
        int                  r, tk;
        logic [PB-1:0]       px;
        logic [NC-1:0]       lit;
        bit                  bnd, swp, xf;
        p = 0; pending = 0; shadow = '0; disp = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                p = 0; pending = 0; shadow = '0; disp = '0;
                q.delete();
            end else begin
                e.rows = '1;
                e.cols = '1;
                if (en) begin
                    r  = (p / SLOT) % NR;
                    tk = (p % SLOT) / PRESCALE;
                    if (tk >= BLANK) begin
                        lit = '0;
                        for (int c = 0; c < NC; c++) begin
                            px = disp[(r * NC + c) * PB +: PB];
                            lit[c] = (int'(px) > tk - BLANK);
                        end
                        e.rows = ~(NR'(1) << r);
                        e.cols = ~lit;
                    end
                end
                xf  = valid && !pending;
                bnd = en && (p % FRAME == FRAME - 1);
                swp = pending && (bnd || !en);
                if (swp) begin
                    disp    = shadow;
                    pending = 0;
                end
                if (xf) begin
                    shadow  = pixels;
                    pending = 1;
                end
                p = en ? p + 1 : 0;
                e.start = swp;
                e.ready = !pending;
                q.push_back(e);
            end
        end
    end

    // Monitor: one prediction per clock, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if ({rows, cols, ready, start} !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t rows=%b cols=%b ready=%b start=%b expected rows=%b cols=%b ready=%b start=%b",
                             $time, rows, cols, ready, start, e.rows, e.cols, e.ready, e.start);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_rows"},  int'(rows),  'hF);
        chk({nm, "_cols"},  int'(cols),  'hFF);
        chk({nm, "_ready"}, int'(ready), 1);
        chk({nm, "_start"}, int'(start), 0);
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_start_seen"}, int'(start === 1'b1), 1);
    endtask

    task automatic wait_rows(input string nm, input logic [NR-1:0] want);
        int n = 0;
        while (rows !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_row_seen"}, int'(rows), int'(want));
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int lowcnt[4];
        int act0, blanks, lit_any;
        logic [NR*NC*PB-1:0] frame_b;

        rst_n = 1'b1; en = 1'b0; valid = 1'b0; pixels = '0;
        #1 rst_n = 1'b0;
        #2 chk_reset("reset_noclk");

        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk); en = 1'b1;

        // Blank display after reset: columns never lit
        lit_any = 0;
        repeat (40) begin
            @(negedge clk);
            if (cols !== 8'hFF) lit_any++;
        end
        chk("zero_frame_cols_lit", lit_any, 0);

        // Brightness ramp on row0: c0..c3 = 0,1,2,3
        valid = 1'b1; pixels = '0; pixels[7:0] = 8'hE4;
        @(negedge clk); valid = 1'b0; pixels = '0;
        wait_start("ramp");
        for (int c = 0; c < 4; c++) lowcnt[c] = 0;
        act0 = 0; blanks = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (rows === 4'b1110) begin
                act0++;
                for (int c = 0; c < 4; c++) if (!cols[c]) lowcnt[c]++;
            end
            if (rows === 4'hF) begin
                blanks++;
                if (cols !== 8'hFF) lit_any++;
            end
        end
        chk("row0_active_clocks", act0, 6);
        chk("col0_low", lowcnt[0], 0);
        chk("col1_low", lowcnt[1], 2);
        chk("col2_low", lowcnt[2], 4);
        chk("col3_low", lowcnt[3], 6);
        chk("blank_clocks_per_frame", blanks, 8);
        chk("blank_cols_lit", lit_any, 0);

        // Handshake: A accepted, B held back until the swap frees the shadow
        valid  = 1'b1;
        pixels = {$urandom, $urandom};
        @(negedge clk);
        chk("ready_after_A", int'(ready), 0);
        frame_b = {$urandom, $urandom};
        pixels  = frame_b;
        wait_start("frame_A");
        @(negedge clk);
        chk("ready_after_B", int'(ready), 0);
        valid = 1'b0; pixels = '0;
        run(2 * FRAME + 8);

        // Enable drop mid row2, then restart
        wait_rows("en_drop", 4'b1011);
        en = 1'b0;
        @(negedge clk);
        chk("disable_rows", int'(rows), 'hF);
        chk("disable_cols", int'(cols), 'hFF);
        run(5);
        en = 1'b1;
        run(FRAME + 4);

        // Async reset while a row is lit
        wait_rows("rst_mid", 4'b1101);
        #2 rst_n = 1'b0;
        #1 chk_reset("reset_midpwm");
        @(negedge clk); #2 rst_n = 1'b1;
        lit_any = 0;
        repeat (2 * FRAME) begin
            @(negedge clk);
            if (cols !== 8'hFF) lit_any++;
        end
        chk("post_reset_cols_lit", lit_any, 0);

        // Randomised traffic with occasional enable toggling
        repeat (800) begin
            @(negedge clk);
            if ($urandom_range(0, 63) == 0) en = ~en;
            valid  = ($urandom_range(0, 3) == 0);
            pixels = {$urandom, $urandom};
        end
        valid = 1'b0;
        en    = 1'b1;
        run(FRAME + 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_mux_pwm.md
Name: led_mux_pwm

Overview:
Parametrised successor to the on/off LED row multiplexer: scans an R×C LED matrix one row at a time with per-pixel PWM brightness. Adds a blanking guard between rows against ghosting, and double-buffers frames behind a valid/ready handshake so updates never tear. Sits between the frame-producing logic and the matrix row/column driver pins.

Parameters:
NUM_ROWS, 4, number of matrix rows scanned
NUM_ROWS_WIDTH, 2, width of row index (>= clog2(NUM_ROWS))
NUM_COLS, 8, number of columns driven in parallel
PWM_BITS, 2, bits of brightness per pixel; PWM period = 2^PWM_BITS-1 ticks
PRESCALE, 2, clocks per tick (>=1)
PRESCALE_WIDTH, 2, width of prescale counter
BLANK_TICKS, 1, ticks all-off at start of each row slot (>=0)
ROW_OUTPUT_ACTIVE_LOW, 1, 1: driven row = 0
COL_OUTPUT_ACTIVE_LOW, 1, 1: lit column = 0

Ports:
clk  in  1  system clock
i_rst_n  in  1  asynchronous reset, active low
i_enable  in  1  scan enable
i_pixels  in  NUM_ROWS*NUM_COLS*PWM_BITS  frame; pixel (r,c) at bits [(r*NUM_COLS+c)*PWM_BITS +: PWM_BITS]
i_frame_valid  in  1  i_pixels holds a new frame
o_frame_ready  out  1  shadow buffer free
o_frame_start  out  1  one-clock pulse when displayed frame is swapped
o_rows  out  NUM_ROWS  row drivers
o_cols  out  NUM_COLS  column drivers; bit c = column c

Behaviour:
- Reset (i_rst_n low, immediate, no clock needed): o_rows/o_cols at inactive level (all 1 when active-low, else all 0); o_frame_ready=1; o_frame_start=0; display and shadow buffers = 0; pending=0; row=0, phase=blank, tick and prescale counters=0.
- Prescaler counts 0..PRESCALE-1; tick when it equals PRESCALE-1, then wraps to 0.
- Row slot = BLANK_TICKS blank ticks, then 2^PWM_BITS-1 PWM ticks (k=0..2^PWM_BITS-2). After the last PWM tick row increments; after row NUM_ROWS-1 it wraps to 0 (frame boundary).
- Blank phase: all rows and columns inactive.
- PWM tick k: only the current row is active; column c active iff display pixel(row,c) > k. Value 0 = never lit; max value = lit all PWM ticks.
- All outputs registered: they reflect counter state with exactly 1 clock latency.
- Handshake: transfer when i_frame_valid && o_frame_ready. i_pixels is captured into the shadow buffer, pending=1, and o_frame_ready=0 on the next clock. i_frame_valid with ready low is ignored. Data must be stable only in the transfer cycle.
- Frame boundary with pending=1: shadow is copied to display, pending=0, o_frame_start=1 for one clock, o_frame_ready=1 on the same edge. With pending=0: no pulse, the display keeps the old frame.
- Transfer in the same cycle as a boundary (pending was 0): the shadow is captured but not swapped until the next boundary.
- i_enable low: on the next clock, outputs go inactive and counters reset to row 0/blank/0. A pending frame is swapped immediately, with o_frame_start pulsed. The handshake stays operational. On re-enable, the scan starts at row 0 blank.
- Reset mid-frame discards both buffers; no partial frame is shown afterwards.

Test Plan:
- Reset: i_rst_n=0 with clk stopped -> o_rows=4'hF, o_cols=8'hFF, o_frame_ready=1, o_frame_start=0. Release and run with all pixels 0 -> o_cols stays 8'hFF.
- Brightness: defaults, row0 pixels c0..c3 = 0,1,2,3 (others 0), valid pulse -> o_frame_start after the first boundary. Then in row0 with o_rows=4'b1110, col0 is never low, col1 is low 2 clocks, col2 is low 4 clocks, col3 is low 6 clocks per 8-clock slot.
- Blanking/scan order: for the first 2 clocks of each slot, o_rows=4'hF and o_cols=8'hFF. Active row sequence is 1110, 1101, 1011, 0111, 1110 with a 32-clock frame period.
- Handshake: assert frame A, then hold valid with frame B -> ready=0 and B is not accepted until the clock after o_frame_start. B is then captured and displayed one frame later; A is shown intact for a full frame.
- Enable: deassert i_enable mid-row2 -> outputs are inactive on the next clock. Reassert -> the first active row is row0, after 2 blank clocks.
- Async reset mid-PWM tick -> outputs go inactive within the same clock period. After release, o_cols=8'hFF until a new frame is loaded.
